// File: rtl/psum_drain_ctrl.sv
// Small FWFT FIFO used as the drain skid buffer.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: the writer must keep count below DEPTH; flush empties it and beats push/pop.
module psum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Psum GLB readout: on compute_done, reads one X_dim-wide row and streams it out valid/ready.
// Latency: first read the cycle after compute_done, first word out two cycles after that read.
// Backpressure: reads issue only while FIFO count + in-flight read leaves a free slot.
module psum_drain_ctrl #(
    parameter int DATA_BITWIDTH  = 8,
    parameter int ADDR_BITWIDTH  = 10,
    parameter int PSUM_LOAD_ADDR = 0,
    parameter int X_dim          = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      compute_done,
    input  logic                      clear,
    output logic                      r_req_psum,
    output logic [ADDR_BITWIDTH-1:0]  r_addr_psum,
    input  logic [DATA_BITWIDTH-1:0]  r_data_psum,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_BITWIDTH-1:0]  m_data,
    output logic                      m_last,
    output logic [7:0]                m_row,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int TW    = DATA_BITWIDTH + 9;
    localparam int LASTI = X_dim - 1;
    localparam logic [7:0]  LAST_IDX = LASTI[7:0];
    localparam logic [CW:0] DEPTH_V  = FIFO_DEPTH[CW:0];
    localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t          state;
    logic [7:0]      row;
    logic [7:0]      col;
    logic            pending;
    logic            inflight;
    logic            infl_last;
    logic [7:0]      infl_row;
    logic [CW-1:0]   fifo_count;
    logic [TW-1:0]   head;
    logic [CW:0]     occ;
    logic            issue_ok;
    logic            pop;
    logic            drain_done;
    logic [ADDR_BITWIDTH-1:0] rd_addr;

    psum_fifo #(
        .WIDTH (TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (clear),
        .push     (inflight),
        .push_dat ({r_data_psum, infl_last, infl_row}),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count)
    );

    // Every outstanding read owns a FIFO slot, so the return never overflows.
    assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue_ok = occ < DEPTH_V;

    assign rd_addr = ADDR_BITWIDTH'(PSUM_LOAD_ADDR)
                   + ADDR_BITWIDTH'(row) * ADDR_BITWIDTH'(X_dim)
                   + ADDR_BITWIDTH'(col);

    // Combinational so that an asynchronous reset drops the request immediately.
    assign r_req_psum  = (state == DRAIN) && issue_ok && !clear;
    assign r_addr_psum = r_req_psum ? rd_addr : '0;

    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? head[TW-1 -: DATA_BITWIDTH] : '0;
    assign m_last  = m_valid && head[8];
    assign m_row   = m_valid ? head[7:0] : '0;
    assign busy    = (state != IDLE);

    // Row is finished once the last word is leaving this cycle and nothing is outstanding.
    assign drain_done = !inflight && ((fifo_count == '0) || ((fifo_count == ONE) && pop));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            pending    <= 1'b0;
            inflight   <= 1'b0;
            infl_last  <= 1'b0;
            infl_row   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            pending    <= 1'b0;
            inflight   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            inflight   <= r_req_psum;
            infl_last  <= (col == LAST_IDX);
            infl_row   <= row;
            if (compute_done && state != IDLE) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (compute_done || pending) begin
                        state   <= DRAIN;
                        col     <= '0;
                        pending <= pending && compute_done;
                    end
                end
                DRAIN: begin
                    if (r_req_psum) begin
                        if (col == LAST_IDX) begin
                            state <= FLUSH;
                            col   <= '0;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (drain_done) begin
                        state <= IDLE;
                        if (row == LAST_IDX) begin
                            row        <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row <= row + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed bench for psum_drain_ctrl: main instance X_dim=3/DEPTH=4, second instance exercises the issue stall.
module tb_psum_drain_ctrl;
    logic       clk;
    logic       reset;
    logic       compute_done, clear, m_ready;
    logic       r_req;
    logic [9:0] r_addr;
    logic [7:0] r_data;
    logic       m_valid, m_last, busy, frame_done, overrun;
    logic [7:0] m_data, m_row;

    logic       compute_done2, clear2, m_ready2;
    logic       r_req2;
    logic [9:0] r_addr2;
    logic [7:0] r_data2;
    logic       m_valid2, m_last2, busy2, frame_done2, overrun2;
    logic [7:0] m_data2, m_row2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fd_cnt = 0, fd_cyc = 0, pop_cyc = 0;

    logic [9:0]  addr_q[$];
    logic [16:0] word_q[$];
    logic [9:0]  addr2_q[$];
    logic [16:0] word2_q[$];

    psum_drain_ctrl #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(10), .PSUM_LOAD_ADDR(0),
                      .X_dim(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .compute_done(compute_done), .clear(clear),
        .r_req_psum(r_req), .r_addr_psum(r_addr), .r_data_psum(r_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_row(m_row), .busy(busy), .frame_done(frame_done), .overrun(overrun));

    psum_drain_ctrl #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(10), .PSUM_LOAD_ADDR(100),
                      .X_dim(4), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .compute_done(compute_done2), .clear(clear2),
        .r_req_psum(r_req2), .r_addr_psum(r_addr2), .r_data_psum(r_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
        .m_row(m_row2), .busy(busy2), .frame_done(frame_done2), .overrun(overrun2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GLB model: mem[a] = a*3, data one cycle after the request.
    always @(posedge clk) begin
        cyc++;
        r_data  <= 8'(r_addr * 10'd3);
        r_data2 <= 8'(r_addr2 * 10'd3);
    end

    always @(negedge clk) begin
        if (r_req) addr_q.push_back(r_addr);
        if (m_valid && m_ready) begin
            word_q.push_back({m_data, m_last, m_row});
            pop_cyc = cyc;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (r_req2) addr2_q.push_back(r_addr2);
        if (m_valid2 && m_ready2) word2_q.push_back({m_data2, m_last2, m_row2});
    end

    task automatic clear_logs();
        addr_q.delete(); word_q.delete(); addr2_q.delete(); word2_q.delete();
        fd_cnt = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        clear_logs();
    endtask

    // Returns in the cycle after compute_done was sampled (first DRAIN cycle).
    task automatic pulse_cd();
        @(posedge clk); #1 compute_done = 1'b1;
        @(posedge clk); #1 compute_done = 1'b0;
    endtask

    task automatic wait_idle(input bit second, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            if (!(second ? busy2 : busy)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (r_req !== 1'b0) begin miscompares++; $display("FAIL reset_r_req got=%0d exp=0", r_req); end
        vectors++; if (r_addr !== 10'd0) begin miscompares++; $display("FAIL reset_r_addr got=%0d exp=0", r_addr); end
        vectors++; if ({m_valid, m_data, m_last, m_row} !== 18'd0) begin miscompares++;
            $display("FAIL reset_stream got=%0h exp=0", {m_valid, m_data, m_last, m_row}); end
        vectors++; if ({busy, frame_done, overrun} !== 3'b000) begin miscompares++;
            $display("FAIL reset_status got=%b exp=000", {busy, frame_done, overrun}); end
        @(posedge clk); #1 reset = 1'b1;
        clear_logs();
    endtask

    task automatic test_frame();
        bit ok;
        logic [16:0] exp_w;
        logic [7:0] ed, er;
        clear_logs();
        m_ready = 1'b1;
        pulse_cd();
        vectors++; if ({r_req, r_addr} !== {1'b1, 10'd0}) begin miscompares++;
            $display("FAIL frame_first_req got req=%0d addr=%0d exp req=1 addr=0", r_req, r_addr); end
        @(posedge clk); #1;
        vectors++; if ({m_valid, r_addr} !== {1'b0, 10'd1}) begin miscompares++;
            $display("FAIL frame_t2 got valid=%0d addr=%0d exp valid=0 addr=1", m_valid, r_addr); end
        @(posedge clk); #1;
        vectors++; if ({m_valid, m_data} !== {1'b1, 8'd0}) begin miscompares++;
            $display("FAIL frame_first_word got valid=%0d data=%0d exp valid=1 data=0", m_valid, m_data); end
        for (int r = 0; r < 3; r++) begin
            if (r > 0) pulse_cd();
            wait_idle(1'b0, 40, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL frame_timeout row=%0d got busy=1 exp busy=0", r); end
        end
        vectors++; if (frame_done !== 1'b1) begin miscompares++;
            $display("FAIL frame_done_with_busy_fall got=%0d exp=1", frame_done); end
        @(posedge clk); #1;
        vectors++; if (addr_q.size() != 9) begin miscompares++;
            $display("FAIL frame_addr_count got=%0d exp=9", addr_q.size()); end
        for (int i = 0; i < 9 && i < addr_q.size(); i++) begin
            vectors++; if (addr_q[i] !== 10'(i)) begin miscompares++;
                $display("FAIL frame_addr[%0d] got=%0d exp=%0d", i, addr_q[i], i); end
        end
        vectors++; if (word_q.size() != 9) begin miscompares++;
            $display("FAIL frame_word_count got=%0d exp=9", word_q.size()); end
        for (int i = 0; i < 9 && i < word_q.size(); i++) begin
            ed = 8'(3 * i); er = 8'(i / 3);
            exp_w = {ed, (i % 3 == 2), er};
            vectors++; if (word_q[i] !== exp_w) begin miscompares++;
                $display("FAIL frame_word[%0d] got=%h exp=%h", i, word_q[i], exp_w); end
        end
        vectors++; if ({fd_cnt, fd_cyc} != {32'd1, 32'(pop_cyc + 1)}) begin miscompares++;
            $display("FAIL frame_done_timing got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", fd_cnt, fd_cyc, pop_cyc + 1); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [16:0] exp_w [3];
        clear_logs();
        exp_w[0] = {8'd0, 1'b0, 8'd0}; exp_w[1] = {8'd3, 1'b0, 8'd0}; exp_w[2] = {8'd6, 1'b1, 8'd0};
        m_ready = 1'b0;
        pulse_cd();
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (addr_q.size() != 3) begin miscompares++;
            $display("FAIL stall_req_count got=%0d exp=3", addr_q.size()); end
        vectors++; if ({r_req, m_valid, busy} !== 3'b011) begin miscompares++;
            $display("FAIL stall_hold got req/valid/busy=%b exp=011", {r_req, m_valid, busy}); end
        m_ready = 1'b1;
        wait_idle(1'b0, 20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stall_timeout got busy=1 exp busy=0"); end
        vectors++; if (word_q.size() != 3) begin miscompares++;
            $display("FAIL stall_word_count got=%0d exp=3", word_q.size()); end
        for (int i = 0; i < 3 && i < word_q.size(); i++) begin
            vectors++; if (word_q[i] !== exp_w[i]) begin miscompares++;
                $display("FAIL stall_word[%0d] got=%h exp=%h", i, word_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_toggle();
        logic [3:0] pat;
        logic [16:0] exp_w;
        logic [7:0] ed, er;
        int started;
        bit done;
        pat = 4'b1001;
        started = 0;
        done = 1'b0;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            compute_done = 1'b0;
            if (started == 3 && !busy) begin
                done = 1'b1;
                break;
            end
            m_ready = pat[i % 4];
            if (!busy && started < 3) begin
                compute_done = 1'b1;
                started++;
            end
        end
        m_ready = 1'b1;
        vectors++; if (!done) begin miscompares++; $display("FAIL toggle_timeout got started=%0d exp frame drained", started); end
        @(posedge clk); #1;
        vectors++; if (word_q.size() != 9) begin miscompares++;
            $display("FAIL toggle_word_count got=%0d exp=9", word_q.size()); end
        for (int i = 0; i < 9 && i < word_q.size(); i++) begin
            ed = 8'(3 * i); er = 8'(i / 3);
            exp_w = {ed, (i % 3 == 2), er};
            vectors++; if (word_q[i] !== exp_w) begin miscompares++;
                $display("FAIL toggle_word[%0d] got=%h exp=%h", i, word_q[i], exp_w); end
        end
        vectors++; if ({fd_cnt, fd_cyc} != {32'd1, 32'(pop_cyc + 1)}) begin miscompares++;
            $display("FAIL toggle_frame_done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", fd_cnt, fd_cyc, pop_cyc + 1); end
    endtask

    task automatic test_pending();
        bit ok;
        apply_reset();
        pulse_cd();
        @(posedge clk); #1 compute_done = 1'b1;
        @(posedge clk); #1 compute_done = 1'b0;
        wait_idle(1'b0, 20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL pending_timeout got busy=1 exp busy=0"); end
        @(posedge clk); #1;
        vectors++; if ({busy, r_req, r_addr} !== {1'b1, 1'b1, 10'd3}) begin miscompares++;
            $display("FAIL pending_row1_start got busy=%0d req=%0d addr=%0d exp 1 1 3", busy, r_req, r_addr); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL pending_no_overrun got=%0d exp=0", overrun); end
        pulse_cd();
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL pending_first_extra got=%0d exp=0", overrun); end
        pulse_cd();
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL pending_overrun_set got=%0d exp=1", overrun); end
        wait_idle(1'b0, 20, ok);
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pending_row2_start got busy=%0d exp=1", busy); end
        wait_idle(1'b0, 20, ok);
        vectors++; if ({ok, overrun} !== 2'b11) begin miscompares++;
            $display("FAIL pending_overrun_sticky got ok=%0d overrun=%0d exp 1 1", ok, overrun); end
    endtask

    task automatic test_clear();
        bit ok;
        m_ready = 1'b1;
        pulse_cd();
        wait_idle(1'b0, 20, ok);
        m_ready = 1'b0;
        pulse_cd();
        vectors++; if (r_addr !== 10'd3) begin miscompares++; $display("FAIL clear_row1_addr got=%0d exp=3", r_addr); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if ({busy, m_valid} !== 2'b11) begin miscompares++;
            $display("FAIL clear_pre got busy/valid=%b exp=11", {busy, m_valid}); end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        vectors++; if ({m_valid, busy, r_req, overrun} !== 4'b0001) begin miscompares++;
            $display("FAIL clear_post got valid/busy/req/overrun=%b exp=0001", {m_valid, busy, r_req, overrun}); end
        @(posedge clk); #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL clear_discard got valid=%0d exp=0", m_valid); end
        m_ready = 1'b1;
        pulse_cd();
        vectors++; if ({r_req, r_addr} !== {1'b1, 10'd0}) begin miscompares++;
            $display("FAIL clear_row_zero got req=%0d addr=%0d exp 1 0", r_req, r_addr); end
        wait_idle(1'b0, 20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL clear_timeout got busy=1 exp busy=0"); end
    endtask

    task automatic test_async_reset();
        bit ok;
        pulse_cd();
        @(posedge clk); #1;
        vectors++; if ({r_req, r_addr} !== {1'b1, 10'd4}) begin miscompares++;
            $display("FAIL arst_pre got req=%0d addr=%0d exp 1 4", r_req, r_addr); end
        #1 reset = 1'b0;
        #1;
        vectors++; if ({r_req, r_addr, m_valid, busy, frame_done, overrun} !== 15'd0) begin miscompares++;
            $display("FAIL arst_async got req=%0d addr=%0d valid=%0d busy=%0d fd=%0d ovr=%0d exp all 0",
                     r_req, r_addr, m_valid, busy, frame_done, overrun); end
        @(posedge clk); #1 reset = 1'b1;
        clear_logs();
        pulse_cd();
        vectors++; if ({r_req, r_addr} !== {1'b1, 10'd0}) begin miscompares++;
            $display("FAIL arst_restart got req=%0d addr=%0d exp 1 0", r_req, r_addr); end
        wait_idle(1'b0, 20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL arst_timeout got busy=1 exp busy=0"); end
    endtask

    task automatic test_issue_stall();
        bit ok;
        logic [16:0] exp_w [4];
        exp_w[0] = {8'd44, 1'b0, 8'd0}; exp_w[1] = {8'd47, 1'b0, 8'd0};
        exp_w[2] = {8'd50, 1'b0, 8'd0}; exp_w[3] = {8'd53, 1'b1, 8'd0};
        apply_reset();
        m_ready2 = 1'b0;
        @(posedge clk); #1 compute_done2 = 1'b1;
        @(posedge clk); #1 compute_done2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (addr2_q.size() != 2) begin miscompares++;
            $display("FAIL issue_stall_count got=%0d exp=2", addr2_q.size()); end
        vectors++; if ({r_req2, m_valid2} !== 2'b01) begin miscompares++;
            $display("FAIL issue_stall_hold got req/valid=%b exp=01", {r_req2, m_valid2}); end
        m_ready2 = 1'b1;
        wait_idle(1'b1, 30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL issue_stall_timeout got busy=1 exp busy=0"); end
        vectors++; if (addr2_q.size() != 4) begin miscompares++;
            $display("FAIL issue_addr_count got=%0d exp=4", addr2_q.size()); end
        for (int i = 0; i < 4 && i < addr2_q.size(); i++) begin
            vectors++; if (addr2_q[i] !== 10'(100 + i)) begin miscompares++;
                $display("FAIL issue_addr[%0d] got=%0d exp=%0d", i, addr2_q[i], 100 + i); end
        end
        vectors++; if (word2_q.size() != 4) begin miscompares++;
            $display("FAIL issue_word_count got=%0d exp=4", word2_q.size()); end
        for (int i = 0; i < 4 && i < word2_q.size(); i++) begin
            vectors++; if (word2_q[i] !== exp_w[i]) begin miscompares++;
                $display("FAIL issue_word[%0d] got=%h exp=%h", i, word2_q[i], exp_w[i]); end
        end
        vectors++; if ({frame_done2, overrun2} !== 2'b00) begin miscompares++;
            $display("FAIL issue_status got fd/ovr=%b exp=00", {frame_done2, overrun2}); end
    endtask

    initial begin
        reset = 1'b0;
        compute_done = 1'b0; clear = 1'b0; m_ready = 1'b1;
        compute_done2 = 1'b0; clear2 = 1'b0; m_ready2 = 1'b1;
        test_reset();
        test_frame();
        test_stall();
        test_toggle();
        test_pending();
        test_clear();
        test_async_reset();
        test_issue_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
